// File: rtl/max_plus_pkg.sv
// Shared definitions for the packed-array packer/unpacker pair.
package max_plus_pkg;

  localparam int unsigned DEF_N_LANES = 4;
  localparam int unsigned DEF_W       = 1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_e;

endpackage

// File: rtl/array_unpacker_lane_mux.sv
// Pure combinational N_LANES:1 element selector over a packed array.
module lane_mux #(
  parameter int unsigned N_LANES = 4,
  parameter int unsigned W       = 1,
  parameter int unsigned IDX_W   = $clog2(N_LANES)
) (
  input  logic [N_LANES*W-1:0] data,
  input  logic [IDX_W-1:0]     sel,
  output logic [W-1:0]         elem
);

  always_comb begin
    elem = '0;
    for (int k = 0; k < int'(N_LANES); k++) begin
      if (sel == IDX_W'(k)) elem = data[k*W +: W];
    end
  end

endmodule

// File: rtl/array_unpacker.sv
// Serialises one packed array into N_LANES single-element beats, lane 0 first.
module array_unpacker
  import max_plus_pkg::*;
#(
  parameter int unsigned N_LANES = DEF_N_LANES,
  parameter int unsigned W       = DEF_W,
  parameter int unsigned IDX_W   = $clog2(N_LANES)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_LANES*W-1:0] in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [W-1:0]         out_data,
  output logic [IDX_W-1:0]     out_idx,
  output logic                 out_last,
  output logic                 out_valid,
  input  logic                 out_ready
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_LANES - 1);

  state_e                 state;
  logic [N_LANES*W-1:0]   hold;
  logic [IDX_W-1:0]       cnt;
  logic [IDX_W-1:0]       cnt_inc;
  logic [W-1:0]           next_elem;
  logic                   beat_done;

  // Next array is taken on the last beat so streaming has no bubble.
  assign in_ready  = (state == ST_IDLE) | (out_last & out_ready);
  assign beat_done = out_valid & out_ready;
  assign cnt_inc   = cnt + IDX_W'(1);

  lane_mux #(
    .N_LANES (N_LANES),
    .W       (W),
    .IDX_W   (IDX_W)
  ) u_lane_mux (
    .data (hold),
    .sel  (cnt_inc),
    .elem (next_elem)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      hold      <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_idx   <= '0;
      out_last  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            state     <= ST_SEND;
            hold      <= in_data;
            cnt       <= '0;
            out_valid <= 1'b1;
            out_data  <= in_data[W-1:0];
            out_idx   <= '0;
            out_last  <= 1'b0;
          end
        end
        ST_SEND: begin
          if (beat_done) begin
            if (cnt == LAST_IDX) begin
              cnt <= '0;
              if (in_valid) begin
                hold     <= in_data;
                out_data <= in_data[W-1:0];
                out_idx  <= '0;
                out_last <= 1'b0;
              end else begin
                state     <= ST_IDLE;
                out_valid <= 1'b0;
              end
            end else begin
              cnt      <= cnt_inc;
              out_data <= next_elem;
              out_idx  <= cnt_inc;
              out_last <= (cnt_inc == LAST_IDX);
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_array_unpacker.sv
// Bench for array_unpacker: a 4x8 and a 16x1 instance against a beat-queue model.
module tb_array_unpacker;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] a_in_data = '0;
  logic        a_in_valid = 1'b0, a_in_ready, a_out_last, a_out_valid, a_out_ready = 1'b0;
  logic [7:0]  a_out_data;
  logic [1:0]  a_out_idx;

  logic [15:0] b_in_data = '0;
  logic        b_in_valid = 1'b0, b_in_ready, b_out_last, b_out_valid, b_out_ready = 1'b0;
  logic [0:0]  b_out_data;
  logic [3:0]  b_out_idx;

  array_unpacker #(.N_LANES(4), .W(8), .IDX_W(2)) u_dut_a (
    .clk(clk), .rst_n(rst_n),
    .in_data(a_in_data), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .out_data(a_out_data), .out_idx(a_out_idx), .out_last(a_out_last),
    .out_valid(a_out_valid), .out_ready(a_out_ready)
  );

  array_unpacker #(.N_LANES(16), .W(1), .IDX_W(4)) u_dut_b (
    .clk(clk), .rst_n(rst_n),
    .in_data(b_in_data), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .out_data(b_out_data), .out_idx(b_out_idx), .out_last(b_out_last),
    .out_valid(b_out_valid), .out_ready(b_out_ready)
  );

  int n_checks = 0;
  int n_fail   = 0;
  // Expected beats still owed by each instance, encoded {last, idx, data}.
  int qa[$];
  int qb[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int beat(input int d, input int i, input bit l);
    return d | (i << 8) | (int'(l) << 16);
  endfunction

  // One clock: drive at negedge, check, advance the model, wait for next negedge.
  task automatic cycle(input logic aiv, input logic [31:0] ad, input logic aor,
                       input logic biv, input logic [15:0] bd, input logic bor);
    bit a_rdy, b_rdy;
    a_in_valid = aiv; a_in_data = ad; a_out_ready = aor;
    b_in_valid = biv; b_in_data = bd; b_out_ready = bor;
    #1;
    a_rdy = (qa.size() == 0) || (qa.size() == 1 && aor);
    b_rdy = (qb.size() == 0) || (qb.size() == 1 && bor);
    chk("a_out_valid", 32'(a_out_valid), 32'(qa.size() != 0));
    chk("a_in_ready", 32'(a_in_ready), 32'(a_rdy));
    if (qa.size() != 0)
      chk("a_beat", {15'b0, a_out_last, 6'b0, a_out_idx, a_out_data}, qa[0]);
    chk("b_out_valid", 32'(b_out_valid), 32'(qb.size() != 0));
    chk("b_in_ready", 32'(b_in_ready), 32'(b_rdy));
    if (qb.size() != 0)
      chk("b_beat", {15'b0, b_out_last, 4'b0, b_out_idx, 7'b0, b_out_data}, qb[0]);
    if (qa.size() != 0 && aor) void'(qa.pop_front());
    if (aiv && a_rdy)
      for (int k = 0; k < 4; k++) qa.push_back(beat(int'(ad[k*8 +: 8]), k, k == 3));
    if (qb.size() != 0 && bor) void'(qb.pop_front());
    if (biv && b_rdy)
      for (int k = 0; k < 16; k++) qb.push_back(beat(int'(bd[k]), k, k == 15));
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic a_cyc(input logic iv, input logic [31:0] d, input logic ordy);
    cycle(iv, d, ordy, 1'b0, 16'h0, 1'b1);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    // Reset values
    chk("rst_a_valid", 32'(a_out_valid), 32'd0);
    chk("rst_a_ready", 32'(a_in_ready), 32'd1);
    chk("rst_a_data", 32'(a_out_data), 32'd0);
    chk("rst_a_idx", 32'(a_out_idx), 32'd0);
    chk("rst_a_last", 32'(a_out_last), 32'd0);
    chk("rst_b_valid", 32'(b_out_valid), 32'd0);
    chk("rst_b_ready", 32'(b_in_ready), 32'd1);
    rst_n = 1'b1;
    @(negedge clk);

    // Single array
    a_cyc(1'b1, 32'hDDCCBBAA, 1'b1);
    repeat (5) a_cyc(1'b0, 32'h0, 1'b1);

    // Back-to-back: second array offered until it is taken on the 04 beat
    a_cyc(1'b1, 32'h04030201, 1'b1);
    repeat (4) a_cyc(1'b1, 32'h08070605, 1'b1);
    repeat (5) a_cyc(1'b0, 32'h0, 1'b1);

    // Backpressure on element 1
    a_cyc(1'b1, 32'hDDCCBBAA, 1'b1);
    a_cyc(1'b0, 32'h0, 1'b1);
    repeat (3) a_cyc(1'b1, 32'h12345678, 1'b0);
    repeat (4) a_cyc(1'b0, 32'h0, 1'b1);

    // Stall on the last beat with a new array waiting
    a_cyc(1'b1, 32'hDDCCBBAA, 1'b1);
    repeat (3) a_cyc(1'b0, 32'h0, 1'b1);
    repeat (2) a_cyc(1'b1, 32'hA1B2C3D4, 1'b0);
    a_cyc(1'b1, 32'hA1B2C3D4, 1'b1);
    repeat (5) a_cyc(1'b0, 32'h0, 1'b1);

    // Reset asserted between edges while lane 2 is presented
    a_cyc(1'b1, 32'h55667788, 1'b1);
    repeat (2) a_cyc(1'b0, 32'h0, 1'b1);
    chk("pre_rst_idx", 32'(a_out_idx), 32'd2);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(a_out_valid), 32'd0);
    chk("mid_rst_ready", 32'(a_in_ready), 32'd1);
    qa.delete();
    qb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    a_cyc(1'b0, 32'h0, 1'b1);
    a_cyc(1'b1, 32'h11223344, 1'b1);
    chk("post_rst_first", 32'(a_out_data), 32'h44);
    repeat (5) a_cyc(1'b0, 32'h0, 1'b1);

    // 16 x 1-bit sweep
    cycle(1'b0, 32'h0, 1'b1, 1'b1, 16'hA5C3, 1'b1);
    repeat (18) cycle(1'b0, 32'h0, 1'b1, 1'b0, 16'h0, 1'b1);

    // Random traffic on both instances
    for (int n = 0; n < 400; n++) begin
      cycle(1'($urandom_range(0, 3) != 0), $urandom, 1'($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 1)), 16'($urandom), 1'($urandom_range(0, 3) != 0));
    end
    repeat (24) cycle(1'b0, 32'h0, 1'b1, 1'b0, 16'h0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
